// File: rtl/pe_ctx_sequencer_pkg.sv
// Shared opcodes, context word layout and FSM encoding
// for the PE context sequencer.
package pe_ctx_sequencer_pkg;

  localparam int FU     = 4;
  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;

  localparam logic [FU-1:0] OP_ADD  = 4'd0;
  localparam logic [FU-1:0] OP_SUB  = 4'd1;
  localparam logic [FU-1:0] OP_MULT = 4'd2;
  localparam logic [FU-1:0] OP_SLL  = 4'd3;
  localparam logic [FU-1:0] OP_SRL  = 4'd4;
  localparam logic [FU-1:0] OP_AND  = 4'd5;
  localparam logic [FU-1:0] OP_OR   = 4'd6;
  localparam logic [FU-1:0] OP_NOT  = 4'd7;
  localparam logic [FU-1:0] OP_XOR  = 4'd8;

  localparam int OPC_LSB = 0;
  localparam int IMM_BIT = 4;
  localparam int IMM_LSB = 5;

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    logic             use_imm;
    logic [FU-1:0]    op;
  } ctx_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_OPS,
    ST_EXEC,
    ST_OUT
  } state_t;

  function automatic logic needs_b(ctx_word_t w);
    return !w.use_imm && (w.op != OP_NOT);
  endfunction

endpackage

// File: rtl/pe_ctx_mem.sv
// Context register file: synchronous write, asynchronous read.
// Deliberately not reset so contexts survive a sequencer reset.
module pe_ctx_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 21,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_ctx_sequencer.sv
// Context sequencer: gathers operand tokens, drives the
// external FU, registers its result and emits it downstream.
module pe_ctx_sequencer
  import pe_ctx_sequencer_pkg::*;
#(
  parameter int CTX_DEPTH = 16,
  parameter int CFG_W     = 21,
  localparam int AW       = $clog2(CTX_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CFG_W-1:0] cfg_data,
  input  logic             start,
  input  logic [AW:0]      ctx_len,
  input  logic             in_a_valid,
  input  logic [31:0]      in_a_data,
  output logic             in_a_ready,
  input  logic             in_b_valid,
  input  logic [31:0]      in_b_data,
  output logic             in_b_ready,
  output logic [31:0]      fu_a,
  output logic [31:0]      fu_b,
  output logic [FU-1:0]    fu_opcode,
  input  logic [31:0]      fu_result,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             illegal_op
);

  state_t           state;
  logic [AW-1:0]    pc;
  logic [AW:0]      len_q;
  logic [AW:0]      len_c;
  ctx_word_t        ins_q;
  ctx_word_t        rd_ins;
  logic [CFG_W-1:0] rd_word;
  logic [AW-1:0]    rd_addr;
  logic             need_b_q;
  logic             a_got;
  logic             b_got;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             cap_a;
  logic             cap_b;
  logic             have_a;
  logic             have_b;
  logic [31:0]      a_now;
  logic [31:0]      b_now;
  logic [31:0]      b_oper;
  logic             last;
  logic             mem_we;

  assign mem_we = cfg_we && (state == ST_IDLE);

  pe_ctx_mem #(
    .DEPTH (CTX_DEPTH),
    .W     (CFG_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // Read port looks ahead to the instruction about to be loaded.
  assign rd_addr = (state == ST_OUT) ? pc + AW'(1) : '0;
  assign rd_ins  = rd_word;

  assign len_c = (ctx_len > (AW+1)'(CTX_DEPTH))
               ? (AW+1)'(CTX_DEPTH) : ctx_len;
  assign last  = ({1'b0, pc} == len_q - (AW+1)'(1));

  assign cap_a  = in_a_valid && in_a_ready;
  assign cap_b  = in_b_valid && in_b_ready;
  assign have_a = a_got || cap_a;
  assign have_b = !need_b_q || b_got || cap_b;
  assign a_now  = cap_a ? in_a_data : a_q;
  assign b_now  = cap_b ? in_b_data : b_q;

  always_comb begin
    b_oper = b_now;
    if (ins_q.use_imm)
      b_oper = {16'b0, ins_q.imm};
    else if (ins_q.op == OP_NOT)
      b_oper = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      len_q      <= '0;
      ins_q      <= '0;
      need_b_q   <= 1'b0;
      a_got      <= 1'b0;
      b_got      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      in_a_ready <= 1'b0;
      in_b_ready <= 1'b0;
      fu_a       <= '0;
      fu_b       <= '0;
      fu_opcode  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (len_c == '0) begin
              done <= 1'b1;
            end else begin
              busy       <= 1'b1;
              pc         <= '0;
              len_q      <= len_c;
              ins_q      <= rd_ins;
              need_b_q   <= needs_b(rd_ins);
              a_got      <= 1'b0;
              b_got      <= 1'b0;
              in_a_ready <= 1'b1;
              in_b_ready <= needs_b(rd_ins);
              state      <= ST_WAIT_OPS;
            end
          end
        end
        ST_WAIT_OPS: begin
          if (cap_a) begin
            a_q        <= in_a_data;
            a_got      <= 1'b1;
            in_a_ready <= 1'b0;
          end
          if (cap_b) begin
            b_q        <= in_b_data;
            b_got      <= 1'b1;
            in_b_ready <= 1'b0;
          end
          if (have_a && have_b) begin
            fu_opcode <= ins_q.op;
            fu_a      <= a_now;
            fu_b      <= b_oper;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_data  <= fu_result;
          out_valid <= 1'b1;
          if (ins_q.op > OP_XOR) illegal_op <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              pc         <= pc + AW'(1);
              ins_q      <= rd_ins;
              need_b_q   <= needs_b(rd_ins);
              a_got      <= 1'b0;
              b_got      <= 1'b0;
              in_a_ready <= 1'b1;
              in_b_ready <= needs_b(rd_ins);
              state      <= ST_WAIT_OPS;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
